// File: rtl/vm_pkg.sv
// Shared types and constants for the vending-machine controller: FSM states,
// coin values, command encoding and coin-count packing helpers.
package vm_pkg;

  typedef enum logic [2:0] {OCIOSO, ESCOLHIDO, PAGO, TROCO, ENTREGA, FIM} state_t;

  localparam logic [7:0] VAL_25  = 8'd25;
  localparam logic [7:0] VAL_50  = 8'd50;
  localparam logic [7:0] VAL_100 = 8'd100;

  localparam logic [1:0] CMD_ATIVO = 2'd1;

  localparam int OFS_25  = 0;
  localparam int OFS_50  = 8;
  localparam int OFS_100 = 16;

  typedef struct packed {
    logic [7:0] c100;
    logic [7:0] c50;
    logic [7:0] c25;
  } moedas_t;

  function automatic logic [15:0] valor_moedas(input logic [23:0] m);
    return 16'(m[OFS_25 +: 8]) * 16'(VAL_25)
         + 16'(m[OFS_50 +: 8]) * 16'(VAL_50)
         + 16'(m[OFS_100 +: 8]) * 16'(VAL_100);
  endfunction

  function automatic logic [7:0] add8_sat(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hff : s[7:0];
  endfunction

  // A saturated stock count may hold fewer coins than a refund asks for; clamp at 0.
  function automatic logic [7:0] sub8_sat(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : 8'd0;
  endfunction

  function automatic moedas_t soma_sat(input moedas_t a, input moedas_t b);
    moedas_t r;
    r.c25  = add8_sat(a.c25, b.c25);
    r.c50  = add8_sat(a.c50, b.c50);
    r.c100 = add8_sat(a.c100, b.c100);
    return r;
  endfunction

  function automatic moedas_t sub_sat(input moedas_t a, input moedas_t b);
    moedas_t r;
    r.c25  = sub8_sat(a.c25, b.c25);
    r.c50  = sub8_sat(a.c50, b.c50);
    r.c100 = sub8_sat(a.c100, b.c100);
    return r;
  endfunction

endpackage

// File: rtl/vm_controlador_if.sv
// Command/result bundle between the stimulus source and the vending controller.
// Commands are 2-bit levels; only the value 1 counts as active.
interface vm_controlador_if;
  logic [1:0]  escolher;
  logic [1:0]  inserir_dinheiro;
  logic [1:0]  dar_troco;
  logic [7:0]  produto_escolhido;
  logic [7:0]  dinheiro_inserido;
  logic [23:0] moedas_inseridas;
  logic        liberar;
  logic [7:0]  produto_liberado;
  logic [7:0]  troco;
  logic [23:0] moedas_troco;
  logic [15:0] carteira;
  logic        erro;
  logic        ocupado;

  modport master (
    output escolher, inserir_dinheiro, dar_troco, produto_escolhido,
           dinheiro_inserido, moedas_inseridas,
    input  liberar, produto_liberado, troco, moedas_troco, carteira, erro, ocupado
  );

  modport slave (
    input  escolher, inserir_dinheiro, dar_troco, produto_escolhido,
           dinheiro_inserido, moedas_inseridas,
    output liberar, produto_liberado, troco, moedas_troco, carteira, erro, ocupado
  );
endinterface

// File: rtl/vm_troco.sv
// Greedy change iterator: one coin (100, then 50, then 25) per active cycle;
// done when resto reaches 0, fail when the remainder cannot be paid from stock.
module vm_troco import vm_pkg::*; (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        ativo,
  input  logic [15:0] resto_ini,
  input  moedas_t     estoque,
  output logic        done,
  output logic        fail,
  output logic        paga,
  output moedas_t     pago,
  output moedas_t     estoque_nxt,
  output moedas_t     snapshot
);

  logic [15:0] resto_q;
  moedas_t     snap_q;
  moedas_t     pago_q;
  logic [7:0]  valor;

  assign snapshot = snap_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      resto_q <= '0;
      snap_q  <= '0;
      pago_q  <= '0;
    end else if (start) begin
      resto_q <= resto_ini;
      snap_q  <= estoque;
      pago_q  <= '0;
    end else if (paga) begin
      resto_q <= resto_q - 16'(valor);
      pago_q  <= pago;
    end
  end

  always_comb begin
    done        = 1'b0;
    fail        = 1'b0;
    paga        = 1'b0;
    valor       = 8'd0;
    pago        = pago_q;
    estoque_nxt = estoque;
    if (ativo) begin
      if (resto_q >= 16'(VAL_100) && estoque.c100 != 8'd0) begin
        paga             = 1'b1;
        valor            = VAL_100;
        pago.c100        = pago_q.c100 + 8'd1;
        estoque_nxt.c100 = estoque.c100 - 8'd1;
      end else if (resto_q >= 16'(VAL_50) && estoque.c50 != 8'd0) begin
        paga            = 1'b1;
        valor           = VAL_50;
        pago.c50        = pago_q.c50 + 8'd1;
        estoque_nxt.c50 = estoque.c50 - 8'd1;
      end else if (resto_q >= 16'(VAL_25) && estoque.c25 != 8'd0) begin
        paga            = 1'b1;
        valor           = VAL_25;
        pago.c25        = pago_q.c25 + 8'd1;
        estoque_nxt.c25 = estoque.c25 - 8'd1;
      end else if (resto_q == 16'd0) begin
        done = 1'b1;
      end else begin
        fail = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vm_controlador.sv
// Vending-machine controller: select, bank coins, validate payment, pay change
// greedily one coin per cycle, dispense; liberar arrives k+2 cycles after dar_troco.
module vm_controlador import vm_pkg::*; #(
  parameter int PRECO_P1    = 50,
  parameter int PRECO_P2    = 75,
  parameter int PRECO_P3    = 100,
  parameter int ESTOQUE_25  = 4,
  parameter int ESTOQUE_50  = 4,
  parameter int ESTOQUE_100 = 4
) (
  input logic              clock,
  input logic              reset,
  vm_controlador_if.slave  bus
);

  state_t      state, state_nxt;
  logic [7:0]  cod_q, preco_q, troco_q;
  logic [15:0] valor_q, carteira_q;
  moedas_t     moedas_q, estoque_q, moedas_troco_q;
  logic        erro_q;

  logic    cmd_esc, cmd_ins, cmd_dar, valido, pag_ok, start;
  logic    t_done, t_fail, t_paga;
  moedas_t t_pago, t_estoque, t_snap;

  function automatic logic [7:0] preco_de(input logic [7:0] c);
    case (c)
      8'd1:    return 8'(PRECO_P1);
      8'd2:    return 8'(PRECO_P2);
      8'd3:    return 8'(PRECO_P3);
      default: return 8'd0;
    endcase
  endfunction

  assign cmd_esc = (bus.escolher == CMD_ATIVO);
  assign cmd_ins = (bus.inserir_dinheiro == CMD_ATIVO);
  assign cmd_dar = (bus.dar_troco == CMD_ATIVO);
  assign valido  = (bus.produto_escolhido >= 8'd1) && (bus.produto_escolhido <= 8'd3);
  assign pag_ok  = (valor_q == {8'd0, bus.dinheiro_inserido}) && (valor_q >= {8'd0, preco_q});
  assign start   = (state == PAGO) && cmd_dar && pag_ok;

  vm_troco u_troco (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .ativo       (state == TROCO),
    .resto_ini   (valor_q - {8'd0, preco_q}),
    .estoque     (estoque_q),
    .done        (t_done),
    .fail        (t_fail),
    .paga        (t_paga),
    .pago        (t_pago),
    .estoque_nxt (t_estoque),
    .snapshot    (t_snap)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= OCIOSO;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      OCIOSO:    if (cmd_esc && valido) state_nxt = ESCOLHIDO;
      ESCOLHIDO: if (cmd_ins) state_nxt = PAGO;
      PAGO:      if (cmd_dar) state_nxt = pag_ok ? TROCO : FIM;
      TROCO: begin
        if (t_fail)      state_nxt = FIM;
        else if (t_done) state_nxt = ENTREGA;
      end
      ENTREGA:   state_nxt = FIM;
      FIM:       if (!cmd_dar) state_nxt = OCIOSO;
      default:   state_nxt = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cod_q          <= '0;
      preco_q        <= '0;
      troco_q        <= '0;
      valor_q        <= '0;
      carteira_q     <= '0;
      moedas_q       <= '0;
      moedas_troco_q <= '0;
      erro_q         <= 1'b0;
      estoque_q      <= '{c100: 8'(ESTOQUE_100), c50: 8'(ESTOQUE_50), c25: 8'(ESTOQUE_25)};
    end else begin
      case (state)
        OCIOSO: if (cmd_esc) begin
          if (valido) begin
            cod_q          <= bus.produto_escolhido;
            preco_q        <= preco_de(bus.produto_escolhido);
            erro_q         <= 1'b0;
            troco_q        <= '0;
            moedas_troco_q <= '0;
          end else begin
            erro_q <= 1'b1;
          end
        end
        ESCOLHIDO: if (cmd_ins) begin
          moedas_q  <= bus.moedas_inseridas;
          valor_q   <= valor_moedas(bus.moedas_inseridas);
          estoque_q <= soma_sat(estoque_q, bus.moedas_inseridas);
        end
        PAGO: if (cmd_dar && !pag_ok) begin
          erro_q         <= 1'b1;
          estoque_q      <= sub_sat(estoque_q, moedas_q);
          moedas_troco_q <= moedas_q;
          troco_q        <= valor_q[7:0];
        end
        TROCO: begin
          // Unpayable change: undo partial payout, then hand the customer's coins back.
          if (t_fail) begin
            erro_q         <= 1'b1;
            estoque_q      <= sub_sat(t_snap, moedas_q);
            moedas_troco_q <= moedas_q;
            troco_q        <= valor_q[7:0];
          end else if (t_paga) begin
            estoque_q      <= t_estoque;
            moedas_troco_q <= t_pago;
            troco_q        <= 8'(valor_moedas(t_pago));
          end
        end
        ENTREGA: carteira_q <= carteira_q + {8'd0, preco_q};
        default: ;
      endcase
    end
  end

  assign bus.liberar          = (state == ENTREGA);
  assign bus.produto_liberado = (state == ENTREGA) ? cod_q : 8'd0;
  assign bus.troco            = troco_q;
  assign bus.moedas_troco     = moedas_troco_q;
  assign bus.carteira         = carteira_q;
  assign bus.erro             = erro_q;
  assign bus.ocupado          = (state != OCIOSO);

endmodule

// File: tb/tb_vm_controlador.sv
// Directed bench for vm_controlador: transactions push expected end-of-sale results;
// a monitor pops and compares each time the DUT returns from busy to idle.
module tb_vm_controlador;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic sel   = 1'b0;

  logic [1:0]  cmd_esc = '0, cmd_ins = '0, cmd_dar = '0;
  logic [7:0]  produto = '0, dinheiro = '0;
  logic [23:0] moedas  = '0;

  int tests  = 0;
  int errors = 0;

  always #5 clock = ~clock;

  vm_controlador_if bus_a ();
  vm_controlador_if bus_b ();

  assign bus_a.escolher          = sel ? 2'd0 : cmd_esc;
  assign bus_a.inserir_dinheiro  = sel ? 2'd0 : cmd_ins;
  assign bus_a.dar_troco         = sel ? 2'd0 : cmd_dar;
  assign bus_a.produto_escolhido = produto;
  assign bus_a.dinheiro_inserido = dinheiro;
  assign bus_a.moedas_inseridas  = moedas;
  assign bus_b.escolher          = sel ? cmd_esc : 2'd0;
  assign bus_b.inserir_dinheiro  = sel ? cmd_ins : 2'd0;
  assign bus_b.dar_troco         = sel ? cmd_dar : 2'd0;
  assign bus_b.produto_escolhido = produto;
  assign bus_b.dinheiro_inserido = dinheiro;
  assign bus_b.moedas_inseridas  = moedas;

  vm_controlador dut (.clock(clock), .reset(reset), .bus(bus_a));

  vm_controlador #(.ESTOQUE_25(0), .ESTOQUE_50(0), .ESTOQUE_100(0))
    dut0 (.clock(clock), .reset(reset), .bus(bus_b));

  logic        m_liberar, m_erro, m_ocupado;
  logic [7:0]  m_prod, m_troco;
  logic [23:0] m_moedas, m_stock;
  logic [15:0] m_carteira;

  assign m_liberar  = sel ? bus_b.liberar          : bus_a.liberar;
  assign m_erro     = sel ? bus_b.erro             : bus_a.erro;
  assign m_ocupado  = sel ? bus_b.ocupado          : bus_a.ocupado;
  assign m_prod     = sel ? bus_b.produto_liberado : bus_a.produto_liberado;
  assign m_troco    = sel ? bus_b.troco            : bus_a.troco;
  assign m_moedas   = sel ? bus_b.moedas_troco     : bus_a.moedas_troco;
  assign m_carteira = sel ? bus_b.carteira         : bus_a.carteira;
  assign m_stock    = sel ? dut0.estoque_q         : dut.estoque_q;

  typedef struct {
    int          nlib;
    logic [7:0]  prod;
    logic [7:0]  troco;
    logic [23:0] moedas;
    logic [15:0] carteira;
    logic        erro;
    logic [23:0] stock;
  } exp_t;

  exp_t sbq[$];

  task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nome, act, exp);
    end
  endtask

  task automatic esperar(input int nlib, input logic [7:0] prod, input logic [7:0] troco,
                         input logic [23:0] moe, input logic [15:0] cart, input logic erro,
                         input logic [23:0] stock);
    exp_t e;
    e = '{nlib, prod, troco, moe, cart, erro, stock};
    sbq.push_back(e);
  endtask

  // Monitor: a transaction ends when ocupado falls outside reset.
  initial begin
    bit   in_tx = 0;
    int   nlib  = 0;
    logic [7:0] lprod = '0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        in_tx = 0;
      end else if (m_ocupado) begin
        if (!in_tx) begin
          in_tx = 1;
          nlib  = 0;
          lprod = '0;
        end
        if (m_liberar) begin
          nlib++;
          lprod = m_prod;
        end
      end else if (in_tx) begin
        in_tx = 0;
        if (sbq.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL sb_pop: transaction ended with no expected entry");
        end else begin
          e = sbq.pop_front();
          check("sb_nlib",     nlib,       e.nlib);
          check("sb_prod",     lprod,      e.prod);
          check("sb_troco",    m_troco,    e.troco);
          check("sb_moedas",   m_moedas,   e.moedas);
          check("sb_carteira", m_carteira, e.carteira);
          check("sb_erro",     m_erro,     e.erro);
          check("sb_stock",    m_stock,    e.stock);
        end
      end
    end
  end

  task automatic compra(input logic [7:0] cod, input logic [7:0] din,
                        input logic [23:0] moe, input int lat_exp);
    int lat;
    int n;
    @(negedge clock);
    cmd_esc = 2'd1;
    produto = cod;
    @(negedge clock);
    cmd_esc = 2'd0;
    check("sel_ocupado", m_ocupado, 1);
    check("sel_erro", m_erro, 0);
    cmd_ins  = 2'd1;
    moedas   = moe;
    dinheiro = din;
    @(negedge clock);
    cmd_ins = 2'd0;
    cmd_dar = 2'd1;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (m_liberar && lat < 0) lat = i;
    end
    cmd_dar = 2'd0;
    check("latencia", lat, lat_exp);
    n = 0;
    while (m_ocupado && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("volta_ocioso", m_ocupado, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clock);
    check("rst_liberar",  m_liberar, 0);
    check("rst_prod",     m_prod, 0);
    check("rst_troco",    m_troco, 0);
    check("rst_moedas",   m_moedas, 0);
    check("rst_carteira", m_carteira, 0);
    check("rst_erro",     m_erro, 0);
    check("rst_ocupado",  m_ocupado, 0);
    check("rst_stock",    m_stock, 24'h040404);
    check("rst_stock0",   dut0.estoque_q, 24'h000000);
    reset = 1'b0;

    // P1, 150 in (1x50 + 1x100): one R$1,00 coin back.
    esperar(1, 8'd1, 8'd100, 24'h010000, 16'd50, 1'b0, 24'h040504);
    compra(8'd1, 8'd150, 24'h010100, 3);

    // P2, 100 in (2x25 + 1x50): one R$0,25 coin back.
    esperar(1, 8'd2, 8'd25, 24'h000001, 16'd125, 1'b0, 24'h040605);
    compra(8'd2, 8'd100, 24'h000102, 3);

    @(negedge clock);
    cmd_esc = 2'd1;
    produto = 8'd7;
    @(negedge clock);
    cmd_esc = 2'd0;
    check("inv_erro", m_erro, 1);
    check("inv_ocupado", m_ocupado, 0);

    // P3 with only 75: insufficient, full refund.
    esperar(0, 8'd0, 8'd75, 24'h000003, 16'd125, 1'b1, 24'h040605);
    compra(8'd3, 8'd75, 24'h000003, -1);

    // Declared 150 but coins worth 125: refund.
    esperar(0, 8'd0, 8'd125, 24'h010001, 16'd125, 1'b1, 24'h040605);
    compra(8'd1, 8'd150, 24'h010001, -1);

    // Empty-stock machine: change of 50 cannot be paid.
    sel = 1'b1;
    esperar(0, 8'd0, 8'd100, 24'h010000, 16'd0, 1'b1, 24'h000000);
    compra(8'd1, 8'd100, 24'h010000, -1);
    sel = 1'b0;

    // Reset in the middle of a two-coin payout.
    @(negedge clock);
    cmd_esc = 2'd1;
    produto = 8'd1;
    @(negedge clock);
    cmd_esc  = 2'd0;
    cmd_ins  = 2'd1;
    moedas   = 24'h020000;
    dinheiro = 8'd200;
    @(negedge clock);
    cmd_ins = 2'd0;
    cmd_dar = 2'd1;
    repeat (2) @(negedge clock);
    check("troco_parcial", m_troco, 100);
    check("stock_parcial", m_stock, 24'h050605);
    reset = 1'b1;
    @(negedge clock);
    check("rstx_ocupado",  m_ocupado, 0);
    check("rstx_liberar",  m_liberar, 0);
    check("rstx_troco",    m_troco, 0);
    check("rstx_moedas",   m_moedas, 0);
    check("rstx_carteira", m_carteira, 0);
    check("rstx_erro",     m_erro, 0);
    check("rstx_stock",    m_stock, 24'h040404);
    @(negedge clock);
    reset   = 1'b0;
    cmd_dar = 2'd0;

    // Exact payment, dar_troco held well past the sale: exactly one liberar.
    esperar(1, 8'd2, 8'd0, 24'h000000, 16'd75, 1'b0, 24'h040505);
    compra(8'd2, 8'd75, 24'h000101, 2);

    repeat (3) @(negedge clock);
    check("sb_restante", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/vm_controlador.md
Name: vm_controlador

Overview:
- Vending-machine controller; consumes the command/stimulus stream from the testbench stimulus generator (escolher, inserir_dinheiro, dar_troco, product code, money value, coin counts).
- Validates the product selection and prices it, and banks the inserted coins into a coin stock.
- Computes change and pays it out greedily (R$1,00 then R$0,50 then R$0,25), one coin per cycle, then dispenses the product.
- Accumulates sale prices into a wallet register (carteira). All money values are in centavos.

Parameters:
- PRECO_P1, 50, price of product 1 (centavos)
- PRECO_P2, 75, price of product 2
- PRECO_P3, 100, price of product 3
- ESTOQUE_25, 4, reset count of R$0,25 coins in stock
- ESTOQUE_50, 4, reset count of R$0,50 coins in stock
- ESTOQUE_100, 4, reset count of R$1,00 coins in stock

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- escolher  in  2  ==1: select-product command (level)
- inserir_dinheiro  in  2  ==1: insert-money command (level)
- dar_troco  in  2  ==1: give-change/finish command (level)
- produto_escolhido  in  8  product code; valid codes are 1..3
- dinheiro_inserido  in  8  declared inserted value, centavos
- moedas_inseridas  in  24  [7:0] count of 0,25 coins; [15:8] count of 0,50; [23:16] count of 1,00
- liberar  out  1  one-cycle pulse: product dispensed
- produto_liberado  out  8  code dispensed; valid while liberar=1
- troco  out  8  change value paid, centavos
- moedas_troco  out  24  change coin counts, same packing as moedas_inseridas
- carteira  out  16  accumulated sales, centavos
- erro  out  1  sticky until next accepted selection
- ocupado  out  1  high whenever state != OCIOSO

Behaviour:
- Single clock, clock; reset is synchronous, active-high.
- Reset: all outputs 0; state OCIOSO; coin stock loaded from ESTOQUE_* parameters. Reset in any state aborts the transaction; inserted coins are discarded.
- Commands are sampled on the rising edge of clock. A command value other than 1 is treated as inactive. Commands not listed for the current state are ignored.
- OCIOSO:
  - escolher==1 with a valid code: latch code and price, clear erro, clear troco and moedas_troco, go to ESCOLHIDO.
  - Invalid code (0 or >3): set erro, stay in OCIOSO.
- ESCOLHIDO: inserir_dinheiro==1 does all of the following, then goes to PAGO:
  - latches the coin counts;
  - computes valor = 25*c25 + 50*c50 + 100*c100 as 16-bit;
  - adds the coins to the stock, saturating each count at 255.
- PAGO: dar_troco==1 evaluates in priority order:
  - if valor != dinheiro_inserido, or valor < price: set erro, refund. The refund subtracts the latched coins from the stock, sets moedas_troco = latched coins and troco = valor, goes to FIM, and no liberar.
  - otherwise set resto = valor - price, snapshot the stock, go to TROCO.
- TROCO, once per cycle, in this order:
  - resto >= 100 and s100 > 0: pay one 1,00 coin;
  - else resto >= 50 and s50 > 0: pay one 0,50 coin;
  - else resto >= 25 and s25 > 0: pay one 0,25 coin;
  - else resto == 0: go to ENTREGA;
  - else (change not payable): restore the snapshot, refund as above, set erro, go to FIM.
  - Each payment decrements the stock, decrements resto, increments the matching moedas_troco field, and adds the coin value to troco.
- ENTREGA: one cycle. liberar=1, produto_liberado=code, carteira += price (wrapping at 16 bits), then go to FIM.
- FIM: hold outputs; when dar_troco != 1, go to OCIOSO. This prevents a held dar_troco from retriggering.
- Latency: with k change coins, liberar is high in cycle k+2 after the cycle dar_troco is sampled.

Decomposition:
- Package vm_pkg holds:
  - state enum (OCIOSO, ESCOLHIDO, PAGO, TROCO, ENTREGA, FIM);
  - coin values 25/50/100;
  - command-active code 1;
  - coin-count field offsets 0/8/16.
- Sub-module vm_troco: the greedy change-payment iterator (TROCO loop plus snapshot/restore). It receives the start request, resto and stock, and returns done/fail, the coin counts paid and the updated stock.

Test Plan:
- Product 1, insert 150 (0×25, 1×50, 1×100), dar_troco -> 1 change coin; liberar at +3 cycles; troco=100; moedas_troco=0x010000; carteira=50; stock 25:4, 50:5, 100:4.
- Continue with product 2, insert 100 (2×25, 1×50, 0×100) -> troco=25; moedas_troco=0x000001; carteira=125; stock 25:5.
- Product 3, insert 75 (3×25) -> erro=1; no liberar; refund troco=75, moedas_troco=0x000003; carteira unchanged.
- Reset with ESTOQUE_*=0; product 1, insert 100 (1×100) -> change 50 is not payable -> erro=1; refund moedas_troco=0x010000; stock back to all 0; carteira=0.
- escolher=1 with produto_escolhido=7 -> erro=1, ocupado=0. Separately: declared 150 vs coins worth 125 -> erro and refund.
- Assert reset during TROCO -> next cycle: state OCIOSO, all outputs 0, stock equals the parameters; dar_troco held 5 cycles in FIM gives exactly one liberar.
